// File: rtl/ivl_ovl_step_checker.sv
// Multi-channel step checker: flags per-channel value changes whose step falls outside
// [MIN_STEP, MAX_STEP] in the configured direction, with sticky, count and first-fail capture.
module ivl_ovl_step_checker #(
    parameter int unsigned WIDTH    = 4,
    parameter int unsigned CHANNELS = 1,
    parameter int unsigned MIN_STEP = 1,
    parameter int unsigned MAX_STEP = 1,
    parameter int unsigned MODE     = 0,
    parameter bit          WRAP_EN  = 1'b1,
    parameter int unsigned CNT_W    = 16,
    parameter int unsigned CH_W     = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      enable,
    input  logic                      clear,
    input  logic [CHANNELS*WIDTH-1:0] test_expr,
    output logic [CHANNELS-1:0]       fire,
    output logic [CHANNELS-1:0]       fire_sticky,
    output logic [CNT_W-1:0]          err_count,
    output logic                      first_fail_valid,
    output logic [CH_W-1:0]           first_fail_chan,
    output logic [WIDTH-1:0]          first_fail_prev,
    output logic [WIDTH-1:0]          first_fail_curr
);

    localparam logic [WIDTH-1:0] MIN_V = WIDTH'(MIN_STEP);
    localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MAX_STEP);
    localparam int unsigned      PC_W  = $clog2(CHANNELS + 1);
    localparam int unsigned      SUM_W = CNT_W + PC_W;

    typedef enum logic {
        DISARMED = 1'b0,
        ARMED    = 1'b1
    } ch_state_t;

    ch_state_t        state_q [CHANNELS];
    logic [WIDTH-1:0] prev_q  [CHANNELS];
    logic [WIDTH-1:0] curr_c  [CHANNELS];

    logic [CHANNELS-1:0] fail_c;
    logic [PC_W-1:0]     pop_c;
    logic                hit_c;
    logic [CH_W-1:0]     hit_chan_c;
    logic [WIDTH-1:0]    hit_prev_c;
    logic [WIDTH-1:0]    hit_curr_c;
    logic [CNT_W-1:0]    cnt_base_c;
    logic [SUM_W-1:0]    cnt_sum_c;
    logic [CNT_W-1:0]    cnt_next_c;

    // Legality of one prev->curr transition; a hold always passes.
    function automatic logic step_ok(input logic [WIDTH-1:0] p, input logic [WIDTH-1:0] c);
        logic [WIDTH-1:0] d_up;
        logic [WIDTH-1:0] d_dn;
        logic             up_ok;
        logic             dn_ok;
        logic             ok;
        d_up  = c - p;
        d_dn  = p - c;
        up_ok = (d_up >= MIN_V) && (d_up <= MAX_V) && (WRAP_EN || (c > p));
        dn_ok = (d_dn >= MIN_V) && (d_dn <= MAX_V) && (WRAP_EN || (c < p));
        if (MODE == 0)      ok = up_ok;
        else if (MODE == 1) ok = dn_ok;
        else                ok = up_ok || dn_ok;
        if (c == p)         ok = 1'b1;
        return ok;
    endfunction

    // Per-channel failure detection, popcount and lowest-index failing channel.
    always_comb begin
        fail_c     = '0;
        pop_c      = '0;
        hit_c      = 1'b0;
        hit_chan_c = '0;
        hit_prev_c = '0;
        hit_curr_c = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            curr_c[i] = test_expr[i*WIDTH +: WIDTH];
            fail_c[i] = enable && (state_q[i] == ARMED) &&
                        ($isunknown(curr_c[i]) || !step_ok(prev_q[i], curr_c[i]));
            pop_c     = pop_c + PC_W'(fail_c[i]);
            if (fail_c[i] && !hit_c) begin
                hit_c      = 1'b1;
                hit_chan_c = CH_W'(i);
                hit_prev_c = prev_q[i];
                hit_curr_c = curr_c[i];
            end
        end
    end

    // Clear takes effect before this edge's failures are accumulated; count saturates.
    always_comb begin
        cnt_base_c = clear ? '0 : err_count;
        cnt_sum_c  = SUM_W'(cnt_base_c) + SUM_W'(pop_c);
        cnt_next_c = (cnt_sum_c[SUM_W-1:CNT_W] != '0) ? '1 : cnt_sum_c[CNT_W-1:0];
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            fire             <= '0;
            fire_sticky      <= '0;
            err_count        <= '0;
            first_fail_valid <= 1'b0;
            first_fail_chan  <= '0;
            first_fail_prev  <= '0;
            first_fail_curr  <= '0;
            for (int i = 0; i < CHANNELS; i++) begin
                state_q[i] <= DISARMED;
                prev_q[i]  <= '0;
            end
        end else begin
            fire        <= fail_c;
            fire_sticky <= (clear ? '0 : fire_sticky) | fail_c;
            err_count   <= cnt_next_c;
            if (hit_c && (clear || !first_fail_valid)) begin
                first_fail_valid <= 1'b1;
                first_fail_chan  <= hit_chan_c;
                first_fail_prev  <= hit_prev_c;
                first_fail_curr  <= hit_curr_c;
            end else if (clear) begin
                first_fail_valid <= 1'b0;
                first_fail_chan  <= '0;
                first_fail_prev  <= '0;
                first_fail_curr  <= '0;
            end
            for (int i = 0; i < CHANNELS; i++) begin
                if (enable) begin
                    state_q[i] <= ARMED;
                    prev_q[i]  <= curr_c[i];
                end else begin
                    state_q[i] <= DISARMED;
                end
            end
        end
    end

endmodule

// File: tb/tb_ivl_ovl_step_checker.sv
// Scoreboard bench for ivl_ovl_step_checker: two configurations driven from directed tables,
// expected outputs queued by the drivers and checked by independent monitors.
module tb_ivl_ovl_step_checker;

    typedef struct packed {
        logic [3:0]  fire;
        logic [3:0]  sticky;
        logic [15:0] cnt;
        logic        valid;
        logic [1:0]  chan;
        logic [3:0]  prev;
        logic [3:0]  curr;
    } exp_t;

    typedef struct {
        bit          rst;
        bit          en;
        bit          clr;
        logic [15:0] te;
        exp_t        exp;
    } row_t;

    logic clock;

    // Instance A: W=2, C=1, increment only, step 1, no wrap
    logic        a_reset, a_enable, a_clear;
    logic [1:0]  a_te;
    logic [0:0]  a_fire, a_sticky;
    logic [15:0] a_cnt;
    logic        a_valid;
    logic [0:0]  a_chan;
    logic [1:0]  a_prev, a_curr;

    // Instance B: W=4, C=4, either direction, step 1..2, wrap legal, 4-bit count
    logic        b_reset, b_enable, b_clear;
    logic [15:0] b_te;
    logic [3:0]  b_fire, b_sticky;
    logic [3:0]  b_cnt;
    logic        b_valid;
    logic [1:0]  b_chan;
    logic [3:0]  b_prev, b_curr;

    int total = 0;
    int bad   = 0;

    exp_t q_a[$];
    exp_t q_b[$];
    row_t rows_a[$];
    row_t rows_b[$];

    ivl_ovl_step_checker #(
        .WIDTH(2), .CHANNELS(1), .MIN_STEP(1), .MAX_STEP(1), .MODE(0),
        .WRAP_EN(1'b0), .CNT_W(16)
    ) u_a (
        .clock(clock), .reset(a_reset), .enable(a_enable), .clear(a_clear),
        .test_expr(a_te), .fire(a_fire), .fire_sticky(a_sticky), .err_count(a_cnt),
        .first_fail_valid(a_valid), .first_fail_chan(a_chan),
        .first_fail_prev(a_prev), .first_fail_curr(a_curr)
    );

    ivl_ovl_step_checker #(
        .WIDTH(4), .CHANNELS(4), .MIN_STEP(1), .MAX_STEP(2), .MODE(2),
        .WRAP_EN(1'b1), .CNT_W(4)
    ) u_b (
        .clock(clock), .reset(b_reset), .enable(b_enable), .clear(b_clear),
        .test_expr(b_te), .fire(b_fire), .fire_sticky(b_sticky), .err_count(b_cnt),
        .first_fail_valid(b_valid), .first_fail_chan(b_chan),
        .first_fail_prev(b_prev), .first_fail_curr(b_curr)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    function automatic row_t mk(input bit rst, input bit en, input bit clr, input logic [15:0] te,
                                input logic [3:0] f, input logic [3:0] s, input logic [15:0] c,
                                input logic v, input logic [1:0] ch, input logic [3:0] p,
                                input logic [3:0] cu);
        row_t r;
        r.rst = rst; r.en = en; r.clr = clr; r.te = te;
        r.exp.fire = f; r.exp.sticky = s; r.exp.cnt = c; r.exp.valid = v;
        r.exp.chan = ch; r.exp.prev = p; r.exp.curr = cu;
        return r;
    endfunction

    task automatic check(input string tag, input int row, input string what,
                         input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s row %0d %s: got %h expected %h", tag, row, what, act, req);
        end
    endtask

    task automatic compare_rec(input string tag, input int row, input exp_t act, input exp_t req);
        check(tag, row, "fire", 32'(act.fire), 32'(req.fire));
        check(tag, row, "sticky", 32'(act.sticky), 32'(req.sticky));
        check(tag, row, "err_count", 32'(act.cnt), 32'(req.cnt));
        check(tag, row, "capture", 32'({act.valid, act.chan, act.prev, act.curr}),
              32'({req.valid, req.chan, req.prev, req.curr}));
    endtask

    // Monitors: one record per clock is presented by each DUT after the edge.
    initial begin
        int   idx = 0;
        exp_t act;
        forever begin
            @(posedge clock);
            #1;
            if (q_a.size() != 0) begin
                act = '0;
                act.fire = {3'b0, a_fire}; act.sticky = {3'b0, a_sticky}; act.cnt = a_cnt;
                act.valid = a_valid; act.chan = {1'b0, a_chan};
                act.prev = {2'b0, a_prev}; act.curr = {2'b0, a_curr};
                compare_rec("A", idx, act, q_a.pop_front());
                idx++;
            end
        end
    end

    initial begin
        int   idx = 0;
        exp_t act;
        forever begin
            @(posedge clock);
            #1;
            if (q_b.size() != 0) begin
                act = '0;
                act.fire = b_fire; act.sticky = b_sticky; act.cnt = {12'b0, b_cnt};
                act.valid = b_valid; act.chan = b_chan; act.prev = b_prev; act.curr = b_curr;
                compare_rec("B", idx, act, q_b.pop_front());
                idx++;
            end
        end
    end

    task automatic run_a();
        foreach (rows_a[i]) begin
            @(negedge clock);
            a_reset = rows_a[i].rst; a_enable = rows_a[i].en; a_clear = rows_a[i].clr;
            a_te    = rows_a[i].te[1:0];
            q_a.push_back(rows_a[i].exp);
        end
        @(negedge clock);
        a_clear = 1'b0;
    endtask

    task automatic run_b();
        foreach (rows_b[i]) begin
            @(negedge clock);
            b_reset = rows_b[i].rst; b_enable = rows_b[i].en; b_clear = rows_b[i].clr;
            b_te    = rows_b[i].te;
            q_b.push_back(rows_b[i].exp);
        end
        @(negedge clock);
        b_clear = 1'b0;
    endtask

    initial begin
        a_reset = 1'b1; a_enable = 1'b0; a_clear = 1'b0; a_te = '0;
        b_reset = 1'b1; b_enable = 1'b0; b_clear = 1'b0; b_te = '0;

        //               rst en clr te        fire  sticky cnt v  ch prev curr
        rows_a.push_back(mk(1, 0, 0, 16'h0, 4'h0, 4'h0, 16'd0, 0, 0, 4'h0, 4'h0));
        rows_a.push_back(mk(0, 1, 0, 16'h0, 4'h0, 4'h0, 16'd0, 0, 0, 4'h0, 4'h0));
        rows_a.push_back(mk(0, 1, 0, 16'h1, 4'h0, 4'h0, 16'd0, 0, 0, 4'h0, 4'h0));
        rows_a.push_back(mk(0, 1, 0, 16'h2, 4'h0, 4'h0, 16'd0, 0, 0, 4'h0, 4'h0));
        rows_a.push_back(mk(0, 1, 0, 16'h3, 4'h0, 4'h0, 16'd0, 0, 0, 4'h0, 4'h0));
        rows_a.push_back(mk(0, 1, 0, 16'h0, 4'h1, 4'h1, 16'd1, 1, 0, 4'h3, 4'h0)); // wrap 3->0
        rows_a.push_back(mk(0, 1, 0, 16'h1, 4'h0, 4'h1, 16'd1, 1, 0, 4'h3, 4'h0));
        rows_a.push_back(mk(0, 1, 1, 16'h0, 4'h1, 4'h1, 16'd1, 1, 0, 4'h1, 4'h0)); // clear + 1->0
        rows_a.push_back(mk(0, 1, 0, 16'h0, 4'h0, 4'h1, 16'd1, 1, 0, 4'h1, 4'h0));

        rows_b.push_back(mk(1, 0, 0, 16'h0000, 4'h0, 4'h0, 16'd0,  0, 0, 4'h0, 4'h0));
        rows_b.push_back(mk(0, 1, 0, 16'h9050, 4'h0, 4'h0, 16'd0,  0, 0, 4'h0, 4'h0));
        rows_b.push_back(mk(0, 1, 0, 16'h6081, 4'hA, 4'hA, 16'd2,  1, 1, 4'h5, 4'h8));
        rows_b.push_back(mk(0, 1, 0, 16'h6081, 4'h0, 4'hA, 16'd2,  1, 1, 4'h5, 4'h8));
        rows_b.push_back(mk(0, 1, 0, 16'h6083, 4'h0, 4'hA, 16'd2,  1, 1, 4'h5, 4'h8));
        rows_b.push_back(mk(0, 0, 0, 16'h608C, 4'h0, 4'hA, 16'd2,  1, 1, 4'h5, 4'h8)); // disarmed
        rows_b.push_back(mk(0, 0, 0, 16'h608C, 4'h0, 4'hA, 16'd2,  1, 1, 4'h5, 4'h8));
        rows_b.push_back(mk(0, 1, 0, 16'h608C, 4'h0, 4'hA, 16'd2,  1, 1, 4'h5, 4'h8)); // re-arm
        rows_b.push_back(mk(0, 1, 0, 16'h608D, 4'h0, 4'hA, 16'd2,  1, 1, 4'h5, 4'h8));
        rows_b.push_back(mk(0, 1, 0, 16'hE805, 4'hF, 4'hF, 16'd6,  1, 1, 4'h5, 4'h8));
        rows_b.push_back(mk(0, 1, 0, 16'h608D, 4'hF, 4'hF, 16'd10, 1, 1, 4'h5, 4'h8));
        rows_b.push_back(mk(0, 1, 0, 16'hE805, 4'hF, 4'hF, 16'd14, 1, 1, 4'h5, 4'h8));
        rows_b.push_back(mk(0, 1, 0, 16'h608D, 4'hF, 4'hF, 16'd15, 1, 1, 4'h5, 4'h8)); // saturates
        rows_b.push_back(mk(0, 1, 0, 16'h6085, 4'h1, 4'hF, 16'd15, 1, 1, 4'h5, 4'h8));
        rows_b.push_back(mk(0, 1, 1, 16'h6485, 4'h4, 4'h4, 16'd1,  1, 2, 4'h0, 4'h4)); // clear + fail
        rows_b.push_back(mk(0, 1, 0, 16'hE40D, 4'hB, 4'hF, 16'd4,  1, 2, 4'h0, 4'h4));
        rows_b.push_back(mk(0, 1, 0, 16'h6485, 4'hB, 4'hF, 16'd7,  1, 2, 4'h0, 4'h4));
        rows_b.push_back(mk(1, 1, 0, 16'h6485, 4'h0, 4'h0, 16'd0,  0, 0, 4'h0, 4'h0)); // reset
        rows_b.push_back(mk(0, 1, 0, 16'hE40D, 4'h0, 4'h0, 16'd0,  0, 0, 4'h0, 4'h0)); // arm only
        rows_b.push_back(mk(0, 1, 0, 16'hD40D, 4'h0, 4'h0, 16'd0,  0, 0, 4'h0, 4'h0)); // down 1
        rows_b.push_back(mk(0, 1, 0, 16'hD44D, 4'h2, 4'h2, 16'd1,  1, 1, 4'h0, 4'h4));

        fork
            run_a();
            run_b();
        join

        for (int k = 0; k < 10 && (q_a.size() != 0 || q_b.size() != 0); k++) @(negedge clock);
        if (q_a.size() != 0 || q_b.size() != 0) begin
            total++;
            bad++;
            $display("FAIL drain: %0d/%0d records left, expected 0", q_a.size(), q_b.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
